// File: rtl/eth_pcs_tx_gearbox_pkg.sv
// rtl/eth_pcs_tx_gearbox_pkg.sv - shared 10GBASE-R PCS widths and TX gearbox constants
package eth_pcs_params;

    localparam int W_SYNC            = 2;
    localparam int W_DATA            = 32;
    localparam int W_TX_GEARBOX_CNT  = 6;
    localparam int TX_GEARBOX_PERIOD = 33;

endpackage

// File: rtl/eth_pcs_tx_gearbox.sv
// rtl/eth_pcs_tx_gearbox.sv - 66b to 32b TX gearbox packing header+payload beats into PMA words
module eth_pcs_tx_gearbox #(
    parameter int W_DATA = eth_pcs_params::W_DATA,
    parameter int W_SYNC = eth_pcs_params::W_SYNC
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_hdr_valid,
    input  logic [W_SYNC-1:0] i_hdr,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_ready,
    output logic [W_DATA-1:0] o_pma_data,
    output logic              o_align_err
);
    import eth_pcs_params::W_TX_GEARBOX_CNT;
    import eth_pcs_params::TX_GEARBOX_PERIOD;

    localparam int W_RES    = 2 * W_DATA;
    localparam int W_NEW    = W_DATA + W_SYNC;
    localparam int W_STREAM = W_DATA + W_RES;
    localparam logic [W_TX_GEARBOX_CNT-1:0] PAUSE_CNT = W_TX_GEARBOX_CNT'(TX_GEARBOX_PERIOD - 1);

    logic [W_TX_GEARBOX_CNT-1:0] q_cnt;
    logic                        q_phase;
    logic [W_RES-1:0]            q_res;

    logic [W_TX_GEARBOX_CNT-1:0] r;
    logic [W_NEW-1:0]            new_bits;
    logic [W_STREAM-1:0]         placed;
    logic [W_STREAM-1:0]         shifted;
    logic [W_STREAM-1:0]         stream;
    logic [W_DATA-1:0]           pack_word;
    logic [W_RES-1:0]            pack_res;
    logic                        accept;

    assign accept  = (q_cnt != PAUSE_CNT);
    assign o_ready = accept;

    // Second-half beats carry no header, so the residual is one step longer than q_cnt there.
    assign r = q_cnt + {{(W_TX_GEARBOX_CNT-1){1'b0}}, q_cnt[0]};

    always_comb begin
        new_bits = q_phase ? {i_data, {W_SYNC{1'b0}}} : {i_hdr, i_data};
        placed   = {new_bits, {(W_STREAM-W_NEW){1'b0}}};
        shifted  = '0;
        for (int k = 0; k <= W_DATA; k += 2) begin
            if (r == W_TX_GEARBOX_CNT'(k)) begin
                shifted = placed >> k;
            end
        end
        stream    = {q_res, {W_DATA{1'b0}}} | shifted;
        pack_word = stream[W_STREAM-1 -: W_DATA];
        pack_res  = stream[W_RES-1:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_cnt       <= '0;
            q_phase     <= 1'b0;
            q_res       <= '0;
            o_pma_data  <= '0;
            o_align_err <= 1'b0;
        end else if (accept) begin
            o_pma_data  <= pack_word;
            q_res       <= pack_res;
            q_cnt       <= q_cnt + 1'b1;
            q_phase     <= ~q_phase;
            o_align_err <= (i_hdr_valid == q_phase);
        end else begin
            // Pause: drain the full 32-bit residual, input beat is left pending upstream.
            o_pma_data  <= q_res[W_RES-1 -: W_DATA];
            q_res       <= '0;
            q_cnt       <= '0;
            o_align_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
// tb/tb_eth_pcs_tx_gearbox.sv - randomized bench for eth_pcs_tx_gearbox against a bit-queue model
module tb_eth_pcs_tx_gearbox;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_hdr_valid = 1'b0;
    logic [1:0]  i_hdr = 2'b00;
    logic [31:0] i_data = 32'h0;
    logic        o_ready;
    logic [31:0] o_pma_data;
    logic        o_align_err;

    eth_pcs_tx_gearbox dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_hdr_valid (i_hdr_valid),
        .i_hdr       (i_hdr),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_pma_data  (o_pma_data),
        .o_align_err (o_align_err)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mq[$];
    int          m_acc;
    bit          m_phase;
    logic [31:0] exp_data;
    logic        exp_err;
    int          cyc;
    bit          consumed;
    bit          flip = 1'b0;
    logic [1:0]  src_hdr;
    logic [63:0] src_pay;
    bit          src_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic new_block();
        src_hdr  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        src_pay  = {$urandom, $urandom};
        src_beat = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_acc    = 0;
        m_phase  = 1'b0;
        exp_data = 32'h0;
        exp_err  = 1'b0;
        cyc      = 0;
        consumed = 1'b0;
        new_block();
    endtask

    // Called at posedge+1: check the previous cycle's result, then present a beat and predict.
    task automatic cycle();
        chk("ready", {31'b0, o_ready}, {31'b0, (cyc % 33) != 32});
        chk("pma_data", o_pma_data, exp_data);
        chk("align_err", {31'b0, o_align_err}, {31'b0, exp_err});
        if (consumed) begin
            if (!src_beat) src_beat = 1'b1;
            else new_block();
        end
        i_hdr       = src_hdr;
        i_data      = src_beat ? src_pay[31:0] : src_pay[63:32];
        i_hdr_valid = (src_beat == 1'b0) ^ flip;
        if (m_acc != 32) begin
            if (!m_phase) begin
                mq.push_back(i_hdr[1]);
                mq.push_back(i_hdr[0]);
            end
            for (int b = 31; b >= 0; b--) mq.push_back(i_data[b]);
            exp_err  = (i_hdr_valid != !m_phase);
            m_phase  = !m_phase;
            m_acc++;
            consumed = 1'b1;
        end else begin
            exp_err  = 1'b0;
            m_acc    = 0;
            consumed = 1'b0;
        end
        for (int b = 31; b >= 0; b--) exp_data[b] = mq.pop_front();
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_to(input int target, input string tag);
        int guard;
        guard = 0;
        while (m_acc != target && guard < 40) begin
            cycle();
            guard++;
        end
        n_cmp++;
        assert (guard < 40) else begin
            n_bad++;
            $error("FAIL %s observed=timeout expected=q_cnt_%0d", tag, target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", o_pma_data, 32'h0);
        chk("rst_err", {31'b0, o_align_err}, 32'h0);
        chk("rst_ready", {31'b0, o_ready}, 32'h1);

        i_reset = 1'b0;
        model_reset();
        src_hdr = 2'b01;
        src_pay = 64'h0123_4567_89AB_CDEF;
        cycle();
        chk("first_word", o_pma_data, 32'h4048_D159);
        repeat (110) cycle();

        run_to(4, "reach_cnt4");
        flip = 1'b1;
        cycle();
        flip = 1'b0;
        chk("align_pulse", {31'b0, o_align_err}, 32'h1);
        cycle();
        chk("align_clear", {31'b0, o_align_err}, 32'h0);

        run_to(32, "reach_pause");
        flip = 1'b1;
        cycle();
        flip = 1'b0;
        chk("pause_no_err", {31'b0, o_align_err}, 32'h0);
        repeat (40) cycle();

        run_to(17, "reach_cnt17");
        #3 i_reset = 1'b1;
        #1;
        chk("async_rst_data", o_pma_data, 32'h0);
        chk("async_rst_err", {31'b0, o_align_err}, 32'h0);
        chk("async_rst_ready", {31'b0, o_ready}, 32'h1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_reset();
        repeat (80) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
